// File: rtl/fir_pkg.sv
// Shared types and fixed-point helpers for the FIR library.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} fsm_t;

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Round half up by adding half an LSB, arithmetic shift, then clamp to dw bits.
    function automatic longint round_sat(input longint acc, input int shift, input int dw);
        longint r;
        longint hi;
        longint lo;
        r  = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -(longint'(1) <<< (dw - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

    function automatic int real_to_fix(input real r, input int w);
        real v;
        int  q;
        int  hi;
        int  lo;
        v  = r * (2.0 ** (w - 1));
        q  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (q > hi) return hi;
        if (q < lo) return lo;
        return q;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared multiply-accumulate unit: one product per enabled cycle into a
// non-overflowing accumulator, with a combinational round/saturate output.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DW = 10,
    parameter int CW = 10,
    parameter int AW = 23
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic                 i_acc,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [CW-1:0] i_c,
    output logic signed [DW-1:0] o_res
);

    logic signed [DW+CW-1:0] w_prod;
    logic signed [AW-1:0]    r_acc;

    assign w_prod = i_x * i_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc) begin
                r_acc <= r_acc + {{(AW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
            end
        end
    end

    assign o_res = DW'(round_sat(longint'(r_acc), CW - 1, DW));

endmodule

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel FIR: per-channel circular delay lines in one
// sample bank, runtime-writable coefficients, one shared MAC.
//
//   state | meaning
//   IDLE  | ready for a sample and/or coefficient write
//   MAC   | TAPS cycles, accumulating c[k]*x[n-k] newest to oldest
//   DONE  | register result, strobe out_valid, advance channel pointer
module fir_mc
    import fir_pkg::*;
#(
    parameter int  DW              = 10,
    parameter int  CW              = 10,
    parameter int  TAPS            = 8,
    parameter int  CH              = 2,
    parameter real COEF_INIT [TAPS] = '{TAPS{0.124}}
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_en,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] i_in_ch,
    input  logic signed [DW-1:0]                i_in,
    input  logic                                i_coef_we,
    input  logic [$clog2(TAPS)-1:0]             i_coef_addr,
    input  logic signed [CW-1:0]                i_coef_data,
    output logic                                o_out_valid,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] o_out_ch,
    output logic signed [DW-1:0]                o_out
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int TW  = $clog2(TAPS);
    localparam int AW  = acc_w(DW, CW, TAPS);
    localparam int NB  = CH * TAPS;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);

    logic signed [DW-1:0] r_bank [NB];
    logic signed [CW-1:0] r_coef [TAPS];
    logic signed [CW-1:0] w_coef_init [TAPS];
    logic [TW-1:0]        r_wptr [CH];

    fsm_t                 r_state, w_next;
    logic [TW-1:0]        r_tap;
    logic [CHW-1:0]       r_ch;
    logic                 r_out_valid;
    logic [CHW-1:0]       r_out_ch;
    logic signed [DW-1:0] r_out;

    logic                 w_xfer, w_ch_ok, w_cwe, w_clr, w_acc;
    logic [TW-1:0]        w_rd_pos;
    logic [BW-1:0]        w_rd_idx, w_wr_idx;
    logic signed [DW-1:0] w_res;

    for (genvar g = 0; g < TAPS; g++) begin : g_cinit
        localparam int CINIT = real_to_fix(COEF_INIT[g], CW);
        assign w_coef_init[g] = CW'(CINIT);
    end

    assign o_in_ready = (r_state == IDLE) && i_en;
    assign w_xfer     = i_in_valid && o_in_ready;
    assign w_cwe      = i_coef_we && o_in_ready;
    assign w_ch_ok    = (int'(i_in_ch) < CH);

    // Tap k reads k entries behind the newest sample, wrapping within the channel.
    assign w_rd_pos = (r_wptr[r_ch] >= r_tap) ? (r_wptr[r_ch] - r_tap)
                                              : (r_wptr[r_ch] + TW'(TAPS) - r_tap);
    assign w_rd_idx = BW'(int'(r_ch) * TAPS + int'(w_rd_pos));
    assign w_wr_idx = BW'(int'(i_in_ch) * TAPS + int'(r_wptr[i_in_ch]));

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_acc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && w_ch_ok) begin
                    w_next = MAC;
                    w_clr  = 1'b1;
                end
            end
            MAC: begin
                w_acc = 1'b1;
                if (r_tap == TAP_LAST) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    fir_mac #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_clr (w_clr),
        .i_acc (w_acc),
        .i_x   (r_bank[w_rd_idx]),
        .i_c   (r_coef[r_tap]),
        .o_res (w_res)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_ch        <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out       <= '0;
            for (int i = 0; i < CH; i++)   r_wptr[i] <= '0;
            for (int i = 0; i < NB; i++)   r_bank[i] <= '0;
            for (int k = 0; k < TAPS; k++) r_coef[k] <= w_coef_init[k];
        end else if (i_en) begin
            r_state     <= w_next;
            r_out_valid <= 1'b0;
            if (w_cwe) r_coef[i_coef_addr] <= i_coef_data;
            case (r_state)
                IDLE: begin
                    if (w_xfer && w_ch_ok) begin
                        r_bank[w_wr_idx] <= i_in;
                        r_ch             <= i_in_ch;
                        r_tap            <= '0;
                    end
                end
                MAC: r_tap <= r_tap + TW'(1);
                DONE: begin
                    r_out        <= w_res;
                    r_out_ch     <= r_ch;
                    r_out_valid  <= 1'b1;
                    r_wptr[r_ch] <= (r_wptr[r_ch] == TAP_LAST) ? '0 : r_wptr[r_ch] + TW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_ch    = r_out_ch;
    assign o_out       = r_out;

endmodule

// File: tb/tb_fir_mc.sv
// Directed bench for fir_mc with default parameters (DW=CW=10, TAPS=8, CH=2).
module tb_fir_mc;

    localparam int TAPS = 8;

    logic              clk = 1'b0;
    logic              rst, en, in_valid, in_ready, in_ch;
    logic signed [9:0] in_s, coef_data, out_s;
    logic [2:0]        coef_addr;
    logic              coef_we, out_valid, out_ch;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_mc dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_ch     (in_ch),
        .i_in        (in_s),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_out_valid (out_valid),
        .o_out_ch    (out_ch),
        .o_out       (out_s)
    );

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = addr[2:0];
        coef_data = data[9:0];
        tick;
        coef_we   = 1'b0;
    endtask

    // mode 0 plain, 1 coef0=128 written with the sample, 2 coef1=256 held
    // during MAC, 3 en dropped for three cycles mid-MAC.
    task automatic send(input int ch, input int x, input int mode,
                        output int y, output int ych, output int lat);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_ch    = ch[0];
        in_s     = x[9:0];
        if (mode == 1) begin
            coef_we = 1'b1; coef_addr = 3'd0; coef_data = 10'sd128;
        end
        while (!in_ready && w < 20) begin
            tick;
            w++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        tick;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (mode == 2) begin
            coef_we = 1'b1; coef_addr = 3'd1; coef_data = 10'sd256;
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
            if (lat == TAPS) coef_we = 1'b0;
            if (mode == 3 && lat == 3) en = 1'b0;
            if (mode == 3 && lat == 6) en = 1'b1;
        end
        coef_we = 1'b0;
        if (!out_valid) chk("valid_timeout", 0, 1);
        y   = out_s;
        ych = out_ch;
    endtask

    task automatic impulse(input string tag);
        int y, c, l;
        for (int i = 0; i < 9; i++) begin
            send(0, (i == 0) ? 256 : 0, 0, y, c, l);
            chk({tag, "_out"}, y, (i < 8) ? 32 : 0);
            chk({tag, "_ch"}, c, 0);
            if (i == 0) chk({tag, "_latency"}, l, TAPS + 1);
        end
    endtask

    initial begin
        int y, c, l, seen, w;
        int exp0 [8] = '{32, 63, 95, 126, 158, 189, 221, 252};
        int rdy_q [$];

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_ch = 1'b0; in_s = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out_s, 0);
        chk("rst_out_ch", out_ch, 0);

        impulse("impulse");

        for (int k = 0; k < TAPS; k++) wr_coef(k, 511);
        for (int i = 0; i < 8; i++) send(0, 511, 0, y, c, l);
        chk("sat_pos", y, 511);
        for (int i = 0; i < 8; i++) send(0, -512, 0, y, c, l);
        chk("sat_neg", y, -512);

        rst = 1'b1; tick; rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(i % 2, (i % 2 == 1) ? 0 : 256, 0, y, c, l);
            chk("iso_out_ch", c, i % 2);
            chk("iso_out", y, (i % 2 == 1) ? 0 : exp0[i / 2]);
        end

        send(1, 256, 2, y, c, l);
        chk("mac_we_sample", y, 32);
        send(1, 0, 0, y, c, l);
        chk("mac_we_dropped", y, 32);

        wr_coef(0, 256);
        for (int k = 1; k < TAPS; k++) wr_coef(k, 0);
        send(0, 100, 0, y, c, l);
        chk("coef_100", y, 50);
        send(0, 200, 0, y, c, l);
        chk("coef_200", y, 100);
        send(0, -300, 0, y, c, l);
        chk("coef_m300", y, -150);
        send(0, 200, 1, y, c, l);
        chk("coef_same_cycle", y, 50);

        send(0, 100, 3, y, c, l);
        chk("stall_out", y, 25);
        chk("stall_latency", l, TAPS + 4);

        en = 1'b0;
        tick;
        chk("en0_valid_hold", out_valid, 1);
        chk("en0_in_ready", in_ready, 0);
        tick;
        chk("en0_valid_hold2", out_valid, 1);
        en = 1'b1;
        tick;
        chk("valid_drop", out_valid, 0);
        chk("out_hold", out_s, 25);

        in_valid = 1'b1; in_ch = 1'b0; in_s = '0;
        for (int i = 0; i < 32; i++) begin
            if (in_ready) rdy_q.push_back(i);
            tick;
        end
        in_valid = 1'b0;
        chk("xfer_count", rdy_q.size(), 4);
        if (rdy_q.size() >= 3) begin
            chk("xfer_gap1", rdy_q[1] - rdy_q[0], TAPS + 2);
            chk("xfer_gap2", rdy_q[2] - rdy_q[1], TAPS + 2);
        end
        w = 0;
        while (!in_ready && w < 20) begin
            tick;
            w++;
        end
        chk("drain_ready", in_ready, 1);

        in_valid = 1'b1; in_ch = 1'b0; in_s = 10'sd300;
        tick;
        in_valid = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick;
        end
        chk("rst_mid_no_valid", seen, 0);

        impulse("impulse_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_mc.md
# fir_mc

Multi-channel, time-multiplexed FIR filter with runtime-loadable coefficients. One multiply-accumulate unit is shared across all taps, and per-channel delay lines are stored in a single sample bank. The output is rounded and saturated in fixed point. It sits in the DSP datapath and directly replaces the single-channel, fully parallel FIR when several interleaved streams must be filtered at low sample rates.

## Interface
- DW, 10, sample width; input and output are signed Q1.(DW-1)
- CW, 10, coefficient width; signed Q1.(CW-1)
- TAPS, 8, filter length, ≥2
- CH, 2, number of independent channels, ≥1
- COEF_INIT, '{TAPS{0.124}}, real array; reset value of each coefficient is round(COEF_INIT[k]·2^(CW-1)), saturated to CW bits
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  clock enable; low freezes all state
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample or a coefficient write
- in_ch  in  $clog2(CH) (min 1)  channel of the sample
- in  in  DW  sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index
- coef_data  in  CW  coefficient value
- out_valid  out  1  one-cycle result strobe
- out_ch  out  $clog2(CH) (min 1)  channel of the result
- out  out  DW  filtered sample

## Operation
- Transfer rule: a sample transfers on a rising edge when in_valid && in_ready && en.
- Result: y[n] = Σ_{k=0..TAPS-1} c[k]·x_ch[n-k], where x_ch[n] is the sample just transferred. Older history comes from that channel's circular buffer.
- Buffer storage: sample bank holds CH×TAPS entries. Each channel has its own write pointer, which wraps TAPS-1 → 0. Pointers never cross channels.
- FSM states: IDLE, MAC, DONE.
  - IDLE: in_ready=1. On transfer, write the sample at wptr[in_ch], latch the channel, clear the accumulator, go to MAC.
  - MAC: TAPS cycles. On cycle k, accumulate c[k]·x[n-k], reading entries newest to oldest. After the last tap, go to DONE.
  - DONE: register out and out_ch, pulse out_valid, advance wptr, return to IDLE.
- in_ready=0 in MAC and DONE.
- Arithmetic:
  - Products are DW+CW bits.
  - Accumulator is AW = DW+CW+$clog2(TAPS) bits, wide enough that it cannot overflow.
  - Result = (acc + 2^(CW-2)) >>> (CW-1), i.e. round half up, then saturate to [-2^(DW-1), 2^(DW-1)-1].
- Coefficient writes: coef_we is honoured only when in_ready && en; otherwise it is dropped silently.
- Write and sample in the same IDLE cycle: both take effect, and that sample's MAC uses the new coefficient.
- Out-of-range channel (in_ch ≥ CH): the sample transfers, but the bank, pointers and outputs are untouched; the block stays in IDLE.
- en=0: state, counters, accumulator, bank and outputs all hold. in_ready is driven 0. An out_valid already high is held until en returns, then drops after one enabled cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, out=0, out_ch=0. All bank entries and pointers are 0, and coefficients load from COEF_INIT.
- Reset wins over every other input and may arrive mid-MAC; the partial result is discarded and no out_valid is issued.
- Latency, with en held high: a transfer on edge t gives out_valid high in the cycle after edge t+TAPS+1.
- in_ready is high again in the same cycle as out_valid.
- Throughput: one sample per TAPS+2 cycles.
- out and out_ch hold their value between strobes.

## Structure
- Package fir_pkg holds:
  - the fsm_t enum {IDLE, MAC, DONE};
  - function acc_w(DW, CW, TAPS);
  - function round_sat(acc, shift, dw), used by every FIR in the library;
  - function real_to_fix(real, w), for COEF_INIT conversion.
- Sub-module fir_mac owns the multiplier, the accumulator and the clear/accumulate control.
  - Its round/saturate output is combinational; the parent registers it.
- The sample bank and coefficient bank are plain register arrays; no RAM inference is required.

## Test plan
- Impulse response, defaults (coef = 63 each, since 0.124·512 = 63.49): send in=256 (0.5) on ch0, then 8 zeros on ch0. Expected: out = 32 (256·63/512 = 31.5, rounded up) for 8 results, then 0.
- Saturation: write all coefs = 511. Sending 8× in=511 gives a final out = 511; sending 8× in=-512 gives out = -512, with no wrap.
- Channel isolation, CH=2: alternate ch0=256 and ch1=0 for 16 samples. Expected: ch1 outputs all 0; ch0 matches a single-channel model; out_ch alternates 0,1.
- Coefficient load: write coef[0]=256 and the rest 0, with coef_we asserted during MAC (must be dropped), then again in IDLE. Expected: an input stream of 100,200,-300 gives out = 50,100,-150.
- Handshake and stall: hold in_valid continuously. Expected: transfers exactly every TAPS+2 cycles. Dropping en for 3 cycles mid-MAC delays out_valid by exactly 3 cycles with an unchanged value.
- Reset mid-MAC: assert rst on MAC cycle 3. Expected: no out_valid follows, in_ready=1 the next cycle, and the next impulse reproduces the first scenario's response exactly (history cleared).
